// File: rtl/keypad_scan_ctrl_if.sv
// Key-event handshake between the keypad scanner (master) and the note/tone logic (slave).
interface keypad_scan_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_press;

  modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: continuous column strobe, frame-level debounce of single keys,
// press/release events queued in a first-word-fall-through FIFO.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 524288,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         row_in,
  output logic [3:0]         col_out,
  keypad_scan_ctrl_if.master evt,
  output logic               held_valid,
  output logic [3:0]         held_code,
  output logic               overflow
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] AGREE_MAX = CW'(DEBOUNCE);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_EMIT_REL = 2'd1,
    ST_EMIT_PRS = 2'd2
  } state_t;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] lowest_idx16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [SW-1:0] slot_cnt_r;
  logic [1:0]    col_idx_r;
  logic [3:0]    col_r;
  logic          slot_end_s;
  logic          frame_end_s;
  logic [15:0]   snap_r;
  logic [15:0]   snap_nx_s;
  logic [4:0]    ones_s;
  logic          cand_ok_s;
  logic [4:0]    cand_s;
  logic [4:0]    last_r;
  logic [CW-1:0] agree_r;
  state_t        state_r;
  state_t        state_nx_s;
  logic [4:0]    stable_r;
  logic [3:0]    old_code_r;
  logic          fire_s;
  logic          push_s;
  logic [3:0]    push_code_s;
  logic          push_press_s;
  logic [4:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_nx_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nx_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          drop_s;
  logic [4:0]    head_nx_s;
  logic          evt_valid_r;
  logic [3:0]    evt_code_r;
  logic          evt_press_r;
  logic          ovf_r;

  assign slot_end_s  = (slot_cnt_r == SLOT_LAST);
  assign frame_end_s = slot_end_s && (col_idx_r == 2'd3);

  // Column slot timer and one-hot strobe rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b0001;
    end else if (slot_end_s) begin
      slot_cnt_r <= '0;
      col_idx_r  <= col_idx_r + 2'd1;
      col_r      <= {col_r[2:0], col_r[3]};
    end else begin
      slot_cnt_r <= slot_cnt_r + SW'(1);
    end
  end

  // Snapshot bit 4*row+col is the key code; the frame-end view includes the sample taken now
  always_comb begin
    snap_nx_s = snap_r;
    for (int r = 0; r < 4; r++) begin
      snap_nx_s[{r[1:0], col_idx_r}] = row_in[r];
    end
  end

  // Row samples taken on the last cycle of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= 16'd0;
    end else if (slot_end_s) begin
      snap_r <= snap_nx_s;
    end
  end

  // Candidate {key present, code}; chords and ghosting make the frame unusable
  always_comb begin
    ones_s    = popcnt16(snap_nx_s);
    cand_ok_s = (ones_s <= 5'd1);
    if (ones_s == 5'd1) begin
      cand_s = {1'b1, lowest_idx16(snap_nx_s)};
    end else begin
      cand_s = 5'd0;
    end
  end

  // Frame-agreement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r  <= 5'd0;
      agree_r <= '0;
    end else if (frame_end_s && cand_ok_s) begin
      if (cand_s != last_r) begin
        last_r  <= cand_s;
        agree_r <= CW'(1);
      end else if (agree_r != AGREE_MAX) begin
        agree_r <= agree_r + CW'(1);
      end else begin
        agree_r <= agree_r;
      end
    end
  end

  // Event FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Event FSM: a transition emits release-of-old and/or press-of-new, one cycle each
  always_comb begin
    state_nx_s   = state_r;
    fire_s       = 1'b0;
    push_s       = 1'b0;
    push_code_s  = 4'd0;
    push_press_s = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if ((agree_r == AGREE_MAX) && (last_r != stable_r)) begin
          fire_s     = 1'b1;
          state_nx_s = stable_r[4] ? ST_EMIT_REL : ST_EMIT_PRS;
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_EMIT_REL: begin
        push_s       = 1'b1;
        push_code_s  = old_code_r;
        push_press_s = 1'b0;
        state_nx_s   = stable_r[4] ? ST_EMIT_PRS : ST_SCAN;
      end
      ST_EMIT_PRS: begin
        push_s       = 1'b1;
        push_code_s  = stable_r[3:0];
        push_press_s = 1'b1;
        state_nx_s   = ST_SCAN;
      end
      default: begin
        state_nx_s = ST_SCAN;
      end
    endcase
  end

  // Debounced stable state; NONE is encoded as all-zero so held_code reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r   <= 5'd0;
      old_code_r <= 4'd0;
    end else if (fire_s) begin
      old_code_r <= stable_r[3:0];
      stable_r   <= last_r;
    end
  end

  // A push on a full FIFO still lands if the head is being popped in the same cycle
  always_comb begin
    pop_s      = evt_valid_r & evt.evt_ready;
    push_ok_s  = push_s & ((count_r != FIFO_FULL) | pop_s);
    drop_s     = push_s & ~push_ok_s;
    count_nx_s = count_r + {AW'(0), push_ok_s} - {AW'(0), pop_s};
    if (pop_s) begin
      rd_nx_s = rd_ptr_r + AW'(1);
    end else begin
      rd_nx_s = rd_ptr_r;
    end
    if (count_nx_s == '0) begin
      head_nx_s = 5'd0;
    end else if (push_ok_s && (wr_ptr_r == rd_nx_s)) begin
      head_nx_s = {push_press_s, push_code_s};
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // FIFO storage and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 5'd0;
      end
      wr_ptr_r <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {push_press_s, push_code_s};
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end
  end

  // Read side with a registered head so the event outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= '0;
      count_r     <= '0;
      evt_valid_r <= 1'b0;
      evt_code_r  <= 4'd0;
      evt_press_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_nx_s;
      count_r     <= count_nx_s;
      evt_valid_r <= (count_nx_s != '0);
      evt_code_r  <= head_nx_s[3:0];
      evt_press_r <= head_nx_s[4];
      ovf_r       <= ovf_r | drop_s;
    end
  end

  assign col_out       = col_r;
  assign evt.evt_valid = evt_valid_r;
  assign evt.evt_code  = evt_code_r;
  assign evt.evt_press = evt_press_r;
  assign held_valid    = stable_r[4];
  assign held_code     = stable_r[3:0];
  assign overflow      = ovf_r;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a frame-level event model checked every cycle.
module tb_keypad_scan_ctrl;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FD    = 4;
  localparam int FRAME = 4 * SD;

  typedef struct {
    int         at;
    logic [3:0] code;
    logic       press;
  } sched_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        held_valid;
  logic [3:0]  held_code;
  logic        overflow;
  logic [15:0] keys;

  int tests = 0;
  int fails = 0;

  // model state
  int         cyc = 0;
  int         m_last, m_agree, m_stable, m_fire_at, m_fire_to;
  bit         m_ovf;
  logic [4:0] mq[$];
  sched_t     sq[$];

  // observed pops from the DUT
  logic [4:0] got_q[$];
  int         got_cyc[$];
  int         first_valid = -1;

  keypad_scan_ctrl_if bus();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .evt(bus),
    .held_valid(held_valid), .held_code(held_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // keypad matrix: a row reads high when a pressed key sits in the strobed column
  always_comb begin
    row_in = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_out[c] && keys[4*r+c]) row_in[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit full, pop;
    int pc, cand, e;
    if (rst_n !== 1'b1) begin
      cyc = 0; m_last = -1; m_agree = 0; m_stable = -1; m_fire_at = -1; m_fire_to = -1;
      m_ovf = 1'b0; mq.delete(); sq.delete();
      return;
    end
    cyc++;
    full = (mq.size() == FD);
    pop  = (mq.size() > 0) && (bus.evt_ready == 1'b1);
    if (pop) void'(mq.pop_front());
    if (sq.size() > 0) begin
      if (sq[0].at == cyc) begin
        if (!full || pop) mq.push_back({sq[0].press, sq[0].code});
        else m_ovf = 1'b1;
        void'(sq.pop_front());
      end
    end
    if (cyc == m_fire_at) begin
      e = cyc + 1;
      if (m_stable >= 0) begin
        sq.push_back('{at: e, code: 4'(m_stable), press: 1'b0});
        e++;
      end
      m_stable = m_fire_to;
      if (m_stable >= 0) sq.push_back('{at: e, code: 4'(m_stable), press: 1'b1});
      m_fire_at = -1;
    end
    if (cyc % FRAME == 0) begin
      pc = $countones(keys);
      if (pc <= 1) begin
        cand = -1;
        for (int i = 0; i < 16; i++) if (keys[i]) cand = i;
        if (cand != m_last) begin
          m_last  = cand;
          m_agree = 1;
        end else if (m_agree < DB) begin
          m_agree++;
        end
        if (m_agree == DB && m_last != m_stable) begin
          m_fire_at = cyc + 1;
          m_fire_to = m_last;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n === 1'b1) begin
      check("col_out", col_out, 1 << ((cyc / SD) % 4));
      check("evt_valid", bus.evt_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("evt_code", bus.evt_code, mq[0][3:0]);
        check("evt_press", bus.evt_press, mq[0][4]);
      end
      check("held_valid", held_valid, m_stable >= 0);
      check("held_code", held_code, (m_stable < 0) ? 0 : m_stable);
      check("overflow", overflow, m_ovf);
      if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
        got_q.push_back({bus.evt_press, bus.evt_code});
        got_cyc.push_back(cyc);
      end
      if (bus.evt_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_frames(input logic [15:0] k, input int nf);
    keys = k;
    repeat (nf * FRAME) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    keys  = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_out", col_out, 4'b0001);
    check("rst_evt_valid", bus.evt_valid, 1'b0);
    check("rst_held_valid", held_valid, 1'b0);
    check("rst_held_code", held_code, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_cols [4];
    int         start;
    exp_cols = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    keys  = 16'd0;
    bus.evt_ready = 1'b1;

    // reset and column rotation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      repeat (SD) @(negedge clk);
      check("col_seq", col_out, exp_cols[i]);
    end

    // single press of key 9 (row 2, column 1)
    start = cyc;
    first_valid = -1;
    got_q.delete(); got_cyc.delete();
    run_frames(16'h0200, 3);
    check("press_latency", first_valid - start, 34);
    check("press_count", got_q.size(), 1);
    if (got_q.size() > 0) check("press_evt", got_q[0], 5'h19);
    check("press_held_valid", held_valid, 1'b1);
    check("press_held_code", held_code, 4'd9);
    run_frames(16'h0000, 3);

    // one-frame bounce on key 5
    got_q.delete(); got_cyc.delete();
    run_frames(16'h0020, 1);
    run_frames(16'h0000, 3);
    check("bounce_count", got_q.size(), 0);
    check("bounce_held", held_valid, 1'b0);

    // key 0, direct change to key 15, release
    got_q.delete(); got_cyc.delete();
    run_frames(16'h0001, 3);
    run_frames(16'h8000, 3);
    run_frames(16'h0000, 3);
    check("chg_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("chg_evt0", got_q[0], 5'h10);
      check("chg_evt1", got_q[1], 5'h00);
      check("chg_evt2", got_q[2], 5'h1F);
      check("chg_evt3", got_q[3], 5'h0F);
      check("chg_back_to_back", got_cyc[2] - got_cyc[1], 1);
    end

    // chord 2+7 while key 2 is stable
    got_q.delete(); got_cyc.delete();
    run_frames(16'h0004, 3);
    run_frames(16'h0084, 4);
    check("chord_count", got_q.size(), 1);
    if (got_q.size() > 0) check("chord_evt", got_q[0], 5'h12);
    check("chord_held_code", held_code, 4'd2);
    check("chord_held_valid", held_valid, 1'b1);
    run_frames(16'h0000, 3);

    // reset with an event queued drops it
    bus.evt_ready = 1'b0;
    run_frames(16'h0010, 3);
    check("queued_before_rst", bus.evt_valid, 1'b1);
    do_reset();

    // overflow: five events into a four-entry FIFO
    got_q.delete(); got_cyc.delete();
    run_frames(16'h0002, 3);
    run_frames(16'h0000, 3);
    run_frames(16'h0008, 3);
    run_frames(16'h0000, 3);
    check("ovf_full_no_drop", overflow, 1'b0);
    run_frames(16'h0002, 3);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head_code", bus.evt_code, 4'd1);
    bus.evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drain_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("ovf_evt0", got_q[0], 5'h11);
      check("ovf_evt1", got_q[1], 5'h01);
      check("ovf_evt2", got_q[2], 5'h13);
      check("ovf_evt3", got_q[3], 5'h03);
    end
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_empty", bus.evt_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad of the digital piano. It strobes the keypad columns, samples the row returns and debounces the result over whole scan frames. Debounced press and release transitions go into a small event FIFO with a valid/ready handshake for the note/tone logic. It replaces free-running scan-and-stop behaviour with a continuous, frame-based scheduler that never halts the column sequence.

## Interface
Parameters:
- SCAN_DIV, 524288: clock cycles per column slot (≥2).
- DEBOUNCE, 3: consecutive agreeing frames required to accept a new stable state (≥1).
- FIFO_DEPTH, 4: event FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- row_in  in  4  keypad row returns (JB inputs), bit r = row r, high = pressed.
- col_out  out  4  one-hot column strobe (JB outputs), bit c = column c.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head; pop when evt_valid & evt_ready.
- evt_code  out  4  key code of head event = 4*row + col.
- evt_press  out  1  1 = press, 0 = release.
- held_valid  out  1  a debounced key is currently held.
- held_code  out  4  code of held key; 0 when none.
- overflow  out  1  sticky: an event was dropped on full FIFO.

## Operation
- Scan: col_out rotates 0001→0010→0100→1000→0001. Each slot lasts SCAN_DIV cycles. Scanning never stops.
- Sampling: row_in is registered on the last cycle of each slot, so the strobe has SCAN_DIV-1 cycles to settle. The four samples form a 16-bit frame snapshot.
- Frame classification at end of column-3 slot:
  - 0 bits set → candidate NONE.
  - exactly 1 bit set → candidate = that key's code.
  - more than 1 bit set (chord or ghosting) → frame discarded; candidate and agree-counter unchanged.
- Debounce:
  - candidate ≠ last candidate → last candidate := candidate, agree-counter := 1.
  - Otherwise agree-counter increments, saturating at DEBOUNCE.
  - When the counter reaches DEBOUNCE and candidate ≠ stable state, a transition fires and stable := candidate.
- Event FSM, states SCAN, EMIT_REL, EMIT_PRS:
  - On a transition, go to EMIT_REL if the old stable state was a key, else EMIT_PRS.
  - EMIT_REL pushes {old code, release}, then goes to EMIT_PRS if the new state is a key, else SCAN.
  - EMIT_PRS pushes {new code, press}, then returns to SCAN.
  - Each emit state lasts exactly one cycle. A direct key A→key B change yields release A then press B on consecutive cycles.
- held_valid/held_code update in the cycle stable changes.
- FIFO is first-word-fall-through. A push on full is dropped and sets overflow, unless a pop happens the same cycle, in which case the push is accepted. Push and pop on empty: the event is stored, nothing is popped. overflow clears only on reset.
- Codes: row index r = bit position in row_in, column index c = bit position in col_out. Key code = {r[1:0], c[1:0]}.

## Timing
- Reset (asynchronous, rst_n low): col_out=0001, slot counter 0, column index 0, evt_valid=0, evt_code=0, evt_press=0, held_valid=0, held_code=0, overflow=0, FIFO empty, stable=NONE, last candidate=NONE, agree-counter 0, FSM=SCAN.
- Reset mid-operation drops all queued events and debounce history. Scanning restarts at column 0 on the first clk edge after rst_n deasserts.
- Frame length is 4*SCAN_DIV cycles.
- Press latency, from frame boundary to event:
  - Transition fires on the clock after the DEBOUNCE-th agreeing frame ends.
  - The event is pushed in the following cycle.
  - evt_valid is high the cycle after the push.
- Outputs are registered. evt_code/evt_press stay stable while evt_valid=1 and evt_ready=0.
- A new transition cannot start while the FSM is in EMIT_*. Frame ends coinciding with EMIT_* are still classified; transitions are evaluated once the FSM is back in SCAN.

## Test plan
SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4 unless noted.
- Reset: after rst_n low then high → col_out=0001, evt_valid=0, held_valid=0, overflow=0. The sequence 0010, 0100, 1000, 0001 follows at 4-cycle intervals.
- Single press: row_in=0100 whenever col_out=0010, held 3 frames, evt_ready=1 → exactly one event {code 9, press}, held_code=9, held_valid=1. evt_valid rises between 32 and 36 cycles after stimulus start.
- Bounce reject: key 5 present for 1 frame only, then none → no event, held_valid stays 0.
- Release and direct change: hold key 0 for 3 frames, switch to key 15 for 3 frames, then none for 3 frames → event sequence {0,press}, {0,release}, {15,press}, {15,release}. Release 0 and press 15 are on consecutive push cycles.
- Chord ignore: keys 2 and 7 together for 4 frames after key 2 is stable → no events, held_code stays 2.
- Overflow: evt_ready=0; press/release keys 1 and 3 in turn to create 5 events → the first 4 are queued, the 5th is dropped, overflow=1. Then evt_ready=1 drains the 4 in order and overflow remains 1.
